change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin-change dispenser for the vending machine: takes a change amount in rupees and pays it out as a sequence of single coins to a coin hopper, largest denomination first, drawing from its own per-denomination coin inventory. It is the payout end of the coin path. The coin acceptor counts one-hot coins in, and this block emits one-hot coins out over a valid/ready handshake. It reports completion or a shortfall.

## Interface
- INIT_CNT, 20: coins of each denomination loaded into inventory at reset (0..31)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to pay out `amount`; sampled only in IDLE
- amount  input  8  change to pay, rupees (0..255)
- coin_out  output  5  one-hot coin being paid: 00001=1, 00010=2, 00100=5, 01000=10, 10000=20
- coin_valid  output  1  coin_out holds a coin for the hopper
- coin_ready  input  1  hopper accepts the coin this cycle
- refill  input  1  add one coin of `refill_coin` to inventory
- refill_coin  input  5  one-hot denomination being refilled
- busy  output  1  payout in progress (SELECT or ISSUE)
- done  output  1  one-cycle pulse: full amount paid
- short  output  1  one-cycle pulse: payout stopped, inventory cannot cover the remainder
- remain  output  8  amount still unpaid; valid while busy and during done/short
- empty  output  5  per-denomination flag, bit i high when inventory count i is 0

## Operation
- Inventory: five 5-bit counters cnt[0..4] for 1,2,5,10,20. Reset loads INIT_CNT into each.
- FSM states: IDLE, SELECT, ISSUE, DONE, FAIL. All outputs registered.
- IDLE: when start=1, load remain<=amount and go to SELECT.
- SELECT: greedy choice.
  - If remain==0, go to DONE.
  - Otherwise pick the largest denomination d with d<=remain and cnt[d]>0. Set coin_out to d and coin_valid<=1, then go to ISSUE.
  - If no such d exists, go to FAIL.
  - Greedy only. No backtracking: remain=6 with no 1-coins and a 5 available fails with remain=1.
- ISSUE: hold coin_out and coin_valid stable until coin_ready=1.
  - On the handshake cycle: remain<=remain-d, cnt[d]<=cnt[d]-1, coin_valid<=0, coin_out<=0, then go to SELECT.
- DONE: done=1 for exactly one cycle with remain=0, then IDLE.
- FAIL: short=1 for exactly one cycle with remain holding the unpaid amount, then IDLE. Inventory stays as decremented by coins already paid.
- start outside IDLE is ignored. amount is sampled only at acceptance.
- Refill:
  - Legal in any state.
  - If refill_coin is exactly one-hot, cnt[i]<=cnt[i]+1, saturating at 31.
  - A non-one-hot value, including 0, is ignored.
- Simultaneous refill and handshake on the same denomination: count unchanged (net +1-1). At 31, the result is 30+1=31.
- A refill that lands during SELECT is visible to the next SELECT evaluation, not the current one.
- Reset at any time, including mid-ISSUE: state goes to IDLE and the payout is abandoned with no done/short. Counters return to INIT_CNT.
- Arithmetic: remain is 8-bit and never underflows, because d<=remain is guaranteed at selection.

## Timing
- Reset values:
  - coin_out=0, coin_valid=0, busy=0, done=0, short=0, remain=0
  - empty=0 if INIT_CNT>0, else 5'b11111
- start sampled at edge N puts the block in SELECT after N, with busy=1.
- First coin_valid is high after edge N+1.
- With coin_ready held high, each coin takes 2 cycles (SELECT + ISSUE). The handshake occurs on the first cycle coin_valid is high.
- A payout of k coins with ready always high:
  - done goes high after edge N+2k+1, for one cycle.
  - busy is low in that same cycle.
  - start is accepted again at the following edge.
- amount=0: done pulses after edge N+1 and no coin is issued.
- empty reflects counters with one cycle of register latency.

## Test plan
- Reset, then start with amount=38 and coin_ready=1. Required:
  - coins 10000, 01000, 00100, 00010, 00001 on consecutive handshakes
  - done pulse after edge N+11
  - counters 19,19,19,19,19
- INIT_CNT=1, amount=40. Required:
  - coins 20,10,5,2,1 are paid
  - short pulse with remain=2
  - empty=5'b11111, no done
- amount=25, coin_ready low for 3 cycles after first coin_valid. Required:
  - coin_out=10000 stable across the stall
  - cnt[4] decrements only on the ready cycle
  - the 5-coin follows and done pulses
- Saturation and collision: refill 20-coins up to cnt[4]=31, with a further refill holding it at 31. Then refill 10000 in the same cycle as a 20-coin handshake. Required: cnt[4] stays 31. A refill_coin=00011 is ignored.
- Assert rst while coin_valid=1 mid-payout. Required:
  - coin_valid, busy, and remain go to 0 immediately
  - counters return to INIT_CNT
  - no done/short
  - a later start with amount=0 gives done two cycles after start

Source files
------------

// File: rtl/change_dispenser.sv
// Coin-change payout: greedy largest-first coin issue from a per-denomination
// inventory, one-hot coins out over valid/ready, done/short completion pulses.
module change_dispenser #(
  parameter int unsigned INIT_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  output logic [4:0] coin_out,
  output logic       coin_valid,
  input  logic       coin_ready,
  input  logic       refill,
  input  logic [4:0] refill_coin,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [7:0] remain,
  output logic [4:0] empty
);

  localparam logic [4:0] INIT5 = 5'(INIT_CNT);
  localparam logic [4:0] EMPTY_RST = (INIT_CNT > 0) ? 5'b00000 : 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       coin_out_q, coin_out_d;
  logic             coin_valid_q, coin_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [7:0]       remain_q, remain_d;
  logic [4:0]       empty_q, empty_d;
  logic [4:0][4:0]  cnt_q, cnt_d;

  logic [4:0] dec;
  logic       refill_oh;
  logic       sel_found;
  logic [2:0] sel_idx;

  function automatic logic [7:0] denom(input logic [2:0] idx);
    logic [7:0] v;
    unique case (idx)
      3'd0:    v = 8'd1;
      3'd1:    v = 8'd2;
      3'd2:    v = 8'd5;
      3'd3:    v = 8'd10;
      3'd4:    v = 8'd20;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] coin_val(input logic [4:0] oh);
    logic [7:0] v;
    unique case (1'b1)
      oh[0]:   v = 8'd1;
      oh[1]:   v = 8'd2;
      oh[2]:   v = 8'd5;
      oh[3]:   v = 8'd10;
      oh[4]:   v = 8'd20;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Ascending scan: the last match is the largest usable denomination.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (cnt_q[i] != 5'd0 && denom(3'(i)) <= remain_q) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    coin_out_d   = coin_out_q;
    coin_valid_d = coin_valid_q;
    remain_d     = remain_q;
    dec          = 5'b00000;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d = amount;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remain_q == 8'd0) begin
          state_d = S_DONE;
        end else if (sel_found) begin
          coin_out_d   = 5'b00001 << sel_idx;
          coin_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_ISSUE: begin
        if (coin_ready) begin
          dec          = coin_out_q;
          remain_d     = remain_q - coin_val(coin_out_q);
          coin_valid_d = 1'b0;
          coin_out_d   = 5'b00000;
          state_d      = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_SELECT) || (state_d == S_ISSUE);
    done_d  = (state_d == S_DONE);
    short_d = (state_d == S_FAIL);
  end

  assign refill_oh = refill && $onehot(refill_coin);

  // Paid coin leaves first, then the refill saturates: 31 -1 +1 stays 31.
  always_comb begin
    cnt_d   = cnt_q;
    empty_d = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i] - 5'(dec[i]);
      if (refill_oh && refill_coin[i] && cnt_d[i] != 5'd31) begin
        cnt_d[i] = cnt_d[i] + 5'd1;
      end
      empty_d[i] = (cnt_q[i] == 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      coin_out_q   <= 5'b00000;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      remain_q     <= 8'd0;
      empty_q      <= EMPTY_RST;
      cnt_q        <= {5{INIT5}};
    end else begin
      state_q      <= state_d;
      coin_out_q   <= coin_out_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      short_q      <= short_d;
      remain_q     <= remain_d;
      empty_q      <= empty_d;
      cnt_q        <= cnt_d;
    end
  end

  assign coin_out   = coin_out_q;
  assign coin_valid = coin_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short      = short_q;
  assign remain     = remain_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser against a greedy
// arithmetic payout model; plus a small-inventory instance for shortfall.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = 8'd0;
  logic [4:0] coin_out;
  logic       coin_valid;
  logic       coin_ready = 1'b1;
  logic       refill = 1'b0;
  logic [4:0] refill_coin = 5'b0;
  logic       busy, done, short_o;
  logic [7:0] remain;
  logic [4:0] empty;

  logic       b_start = 1'b0;
  logic [7:0] b_amount = 8'd0;
  logic [4:0] b_coin_out;
  logic       b_valid;
  logic       b_busy, b_done, b_short;
  logic [7:0] b_remain;
  logic [4:0] b_empty;

  always #5 clk = ~clk;

  change_dispenser #(.INIT_CNT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .coin_out(coin_out), .coin_valid(coin_valid), .coin_ready(coin_ready),
    .refill(refill), .refill_coin(refill_coin), .busy(busy), .done(done),
    .short(short_o), .remain(remain), .empty(empty)
  );

  change_dispenser #(.INIT_CNT(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .amount(b_amount),
    .coin_out(b_coin_out), .coin_valid(b_valid), .coin_ready(1'b1),
    .refill(1'b0), .refill_coin(5'b00000), .busy(b_busy), .done(b_done),
    .short(b_short), .remain(b_remain), .empty(b_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail1(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic logic [4:0] oh(input int d);
    case (d)
      1:       return 5'b00001;
      2:       return 5'b00010;
      5:       return 5'b00100;
      10:      return 5'b01000;
      20:      return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference inventory and expected-response queues.
  int inv[5];
  int dv[5] = '{1, 2, 5, 10, 20};
  int exp_coin[$];
  int exp_kind[$];
  int exp_rem[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       coin_ready = 1'b1;
      1:       coin_ready = ($urandom_range(0, 3) != 0);
      default: coin_ready = 1'b0;
    endcase
  end

  int         end_cnt = 0;
  int         end_cyc = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [4:0] pc = 5'b0;
  int         m_e, m_k, m_r;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", coin_valid, 1);
        chk("stall_coin", coin_out, pc);
      end
      if (coin_valid && coin_ready) begin
        if (exp_coin.size() == 0) begin
          fail1("unexpected_coin", coin_out, 0);
        end else begin
          m_e = exp_coin.pop_front();
          chk("coin", coin_out, oh(m_e));
        end
      end
      if (done || short_o) begin
        chk("busy_at_end", busy, 0);
        if (exp_kind.size() == 0) begin
          fail1("unexpected_end", done ? 1 : 2, 0);
        end else begin
          m_k = exp_kind.pop_front();
          m_r = exp_rem.pop_front();
          chk("end_kind", done ? 1 : 2, m_k);
          chk("end_remain", remain, m_r);
        end
        end_cnt = end_cnt + 1;
        end_cyc = cyc;
      end
      pv = coin_valid;
      pr = coin_ready;
      pc = coin_out;
    end
  end

  // Greedy payout computed directly from the inventory model.
  task automatic model_pay(input int a, output int n, output int fi);
    int rem, best;
    rem = a;
    n = 0;
    fi = -1;
    forever begin
      if (rem == 0) begin
        exp_kind.push_back(1);
        exp_rem.push_back(0);
        break;
      end
      best = -1;
      for (int i = 4; i >= 0; i--)
        if (best < 0 && dv[i] <= rem && inv[i] > 0) best = i;
      if (best < 0) begin
        exp_kind.push_back(2);
        exp_rem.push_back(rem);
        break;
      end
      exp_coin.push_back(dv[best]);
      if (fi < 0) fi = best;
      inv[best]--;
      rem -= dv[best];
      n++;
    end
  endtask

  task automatic check_inv(input string tag);
    logic [4:0] m;
    repeat (2) @(posedge clk);
    #1;
    m = 5'b0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_cnt"}, dut.cnt_q[i], inv[i]);
      if (inv[i] == 0) m[i] = 1'b1;
    end
    chk({tag, "_empty"}, empty, m);
  endtask

  task automatic do_refill(input logic [4:0] rc);
    refill = 1'b1;
    refill_coin = rc;
    @(posedge clk);
    #1;
    refill = 1'b0;
    refill_coin = 5'b0;
    if ($onehot(rc))
      for (int i = 0; i < 5; i++)
        if (rc[i] && inv[i] < 31) inv[i]++;
  endtask

  // Starts a payout from IDLE (called at posedge+1) and waits for its end.
  task automatic go(input int a, input bit collide, input bit stall);
    int n, fi, n_edge, base, mode, c4;
    bit got;
    base = end_cnt;
    model_pay(a, n, fi);
    if (collide && fi >= 0) inv[fi]++;
    if (stall) ready_mode = 2;
    mode = ready_mode;
    start = 1'b1;
    amount = 8'(a);
    @(posedge clk);
    #1;
    start = 1'b0;
    n_edge = cyc;
    if (collide && fi >= 0) begin
      @(posedge clk);
      #1;
      refill = 1'b1;
      refill_coin = oh(dv[fi]);
      @(posedge clk);
      #1;
      refill = 1'b0;
      refill_coin = 5'b0;
    end
    if (stall) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        got = coin_valid;
      end
      chk("stall_seen_valid", got, 1);
      c4 = dut.cnt_q[4];
      repeat (3) begin
        @(negedge clk);
        chk("stall_hold_coin", coin_out, 5'b10000);
        chk("stall_hold_cnt4", dut.cnt_q[4], c4);
      end
      ready_mode = 0;
    end
    for (int t = 0; t < 3000 && end_cnt == base; t++) @(negedge clk);
    if (end_cnt == base) begin
      fail1("payout_timeout", end_cnt, base + 1);
      exp_coin.delete();
      exp_kind.delete();
      exp_rem.delete();
    end else if (mode == 0) begin
      chk("latency", end_cyc - n_edge, 2 * n + 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bc[$];
    int b_rem, b_d, b_s, base;
    bit got;
    logic [4:0] rc;
    int a;
    for (int i = 0; i < 5; i++) inv[i] = 20;

    #1;
    chk("rst_coin_out", coin_out, 0);
    chk("rst_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short_o, 0);
    chk("rst_remain", remain, 0);
    chk("rst_empty", empty, 0);
    chk("rst_b_empty", b_empty, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-coin inventory: 40 exhausts every denomination with 2 unpaid.
    b_start = 1'b1;
    b_amount = 8'd40;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_d = 0;
    b_s = 0;
    b_rem = -1;
    for (int t = 0; t < 60 && b_s == 0; t++) begin
      @(negedge clk);
      if (b_valid) bc.push_back(b_coin_out);
      if (b_done) b_d++;
      if (b_short) begin
        b_s++;
        b_rem = b_remain;
      end
    end
    chk("b_ncoins", bc.size(), 5);
    for (int i = 0; i < 5 && i < bc.size(); i++)
      chk("b_coin", bc[i], oh(dv[4 - i]));
    chk("b_short", b_s, 1);
    chk("b_remain", b_rem, 2);
    chk("b_no_done", b_d, 0);
    repeat (2) @(negedge clk);
    chk("b_empty", b_empty, 5'b11111);
    @(posedge clk);
    #1;

    go(38, 1'b0, 1'b0);
    check_inv("t38");
    go(25, 1'b0, 1'b1);
    check_inv("stall");

    while (inv[4] < 31) do_refill(5'b10000);
    do_refill(5'b10000);
    check_inv("sat");
    go(20, 1'b1, 1'b0);
    check_inv("collide");
    do_refill(5'b00011);
    do_refill(5'b00000);
    check_inv("nonoh");

    // Reset in the middle of a stalled coin.
    ready_mode = 2;
    start = 1'b1;
    amount = 8'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      got = coin_valid;
    end
    chk("mid_valid_seen", got, 1);
    rst = 1'b1;
    exp_coin.delete();
    exp_kind.delete();
    exp_rem.delete();
    for (int i = 0; i < 5; i++) inv[i] = 20;
    #1;
    chk("mid_rst_valid", coin_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_remain", remain, 0);
    for (int i = 0; i < 5; i++) chk("mid_rst_cnt", dut.cnt_q[i], 20);
    base = end_cnt;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_end", end_cnt - base, 0);
    @(posedge clk);
    #1;
    go(0, 1'b0, 1'b0);
    check_inv("post_rst");

    for (int it = 0; it < 80; it++) begin
      ready_mode = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) rc = 5'($urandom_range(0, 31));
        else rc = 5'b00001 << $urandom_range(0, 4);
        do_refill(rc);
      end
      if ($urandom_range(0, 1) == 0) a = int'($urandom_range(0, 60));
      else a = int'($urandom_range(0, 255));
      go(a, 1'b0, 1'b0);
      check_inv("rand");
    end
    ready_mode = 0;
    repeat (2) @(posedge clk);
    chk("queues_drained", exp_coin.size() + exp_kind.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
